// File: rtl/hart_scheduler.sv
// Round-robin fetch scheduler for a four-hart barrel pipeline.
// It keeps a PC and a RUN/WAIT state per hart and issues one eligible hart per unstalled cycle.
module hart_scheduler #(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  hart_enable,
    input  logic        stall,
    input  logic        block_req,
    input  logic [1:0]  block_hart,
    input  logic        wake_valid,
    input  logic [1:0]  wake_hart,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_hart,
    input  logic [31:0] redirect_pc,
    output logic        issue_valid,
    output logic [1:0]  issue_hart,
    output logic [31:0] issue_pc,
    output logic [3:0]  hart_ready,
    output logic        idle
);

    logic [31:0] pc_reg [4];
    logic [3:0]  run_reg;
    logic [1:0]  last_reg;
    logic        issue_valid_reg;
    logic [1:0]  issue_hart_reg;
    logic [31:0] issue_pc_reg;
    logic        idle_reg;

    logic [3:0]  eligible;
    logic        grant_valid;
    logic [1:0]  grant_hart;

    // A hart being blocked this cycle is already excluded from this cycle's grant.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_elig
            assign eligible[gi] = hart_enable[gi] & run_reg[gi] &
                                  ~(block_req && (block_hart == 2'(gi)));
        end
    endgenerate

    always_comb begin
        logic [1:0] idx;
        grant_valid = 1'b0;
        grant_hart  = last_reg;
        idx         = last_reg;
        for (int k = 1; k <= 4; k++) begin
            idx = last_reg + 2'(k);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_hart  = idx;
            end
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_hart
            always_ff @(posedge clk) begin
                if (reset) begin
                    pc_reg[gi]  <= BOOT_PC;
                    run_reg[gi] <= 1'b1;
                end else begin
                    // Block takes precedence over a simultaneous wake of the same hart.
                    if (block_req && (block_hart == 2'(gi))) begin
                        run_reg[gi] <= 1'b0;
                    end else if (wake_valid && (wake_hart == 2'(gi))) begin
                        run_reg[gi] <= 1'b1;
                    end
                    if (redirect_valid && (redirect_hart == 2'(gi))) begin
                        pc_reg[gi] <= redirect_pc;
                    end else if (!stall && grant_valid && (grant_hart == 2'(gi))) begin
                        pc_reg[gi] <= pc_reg[gi] + PC_STEP;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg        <= 2'd3;
            issue_valid_reg <= 1'b0;
            issue_hart_reg  <= 2'd0;
            issue_pc_reg    <= BOOT_PC;
            idle_reg        <= 1'b0;
        end else if (!stall) begin
            if (grant_valid) begin
                issue_valid_reg <= 1'b1;
                issue_hart_reg  <= grant_hart;
                issue_pc_reg    <= pc_reg[grant_hart];
                last_reg        <= grant_hart;
                idle_reg        <= 1'b0;
            end else begin
                issue_valid_reg <= 1'b0;
                idle_reg        <= 1'b1;
            end
        end
    end

    assign issue_valid = issue_valid_reg;
    assign issue_hart  = issue_hart_reg;
    assign issue_pc    = issue_pc_reg;
    assign hart_ready  = run_reg;
    assign idle        = idle_reg;

endmodule

// File: tb/tb_hart_scheduler.sv
// Directed bench for hart_scheduler: round-robin order, block/wake, redirect, stall, idle and reset.
module tb_hart_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hart_enable;
    logic        stall;
    logic        block_req;
    logic [1:0]  block_hart;
    logic        wake_valid;
    logic [1:0]  wake_hart;
    logic        redirect_valid;
    logic [1:0]  redirect_hart;
    logic [31:0] redirect_pc;
    logic        issue_valid;
    logic [1:0]  issue_hart;
    logic [31:0] issue_pc;
    logic [3:0]  hart_ready;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    always #5 clk = ~clk;

    hart_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .hart_enable    (hart_enable),
        .stall          (stall),
        .block_req      (block_req),
        .block_hart     (block_hart),
        .wake_valid     (wake_valid),
        .wake_hart      (wake_hart),
        .redirect_valid (redirect_valid),
        .redirect_hart  (redirect_hart),
        .redirect_pc    (redirect_pc),
        .issue_valid    (issue_valid),
        .issue_hart     (issue_hart),
        .issue_pc       (issue_pc),
        .hart_ready     (hart_ready),
        .idle           (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_no, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 ns later and drop one-shot inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        block_req      = 1'b0;
        wake_valid     = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [1:0] h, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
        chk({tag, "_hart"},  32'(issue_hart),  32'(h));
        chk({tag, "_pc"},    issue_pc,         pc);
        chk({tag, "_idle"},  32'(idle),        32'd0);
        $display("edge %0d: %s hart=%0d pc=%0h valid=%0b idle=%0b ready=%0h",
                 edge_no, tag, issue_hart, issue_pc, issue_valid, idle, hart_ready);
    endtask

    task automatic expect_idle(input string tag, input logic [1:0] h, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
        chk({tag, "_idle"},  32'(idle),        32'd1);
        chk({tag, "_hart"},  32'(issue_hart),  32'(h));
        chk({tag, "_pc"},    issue_pc,         pc);
        $display("edge %0d: %s idle hart=%0d pc=%0h ready=%0h", edge_no, tag, issue_hart, issue_pc, hart_ready);
    endtask

    initial begin
        logic [1:0]  seq_h [8];
        logic [31:0] seq_p [8];

        reset = 1'b1; hart_enable = 4'hF; stall = 1'b0;
        block_req = 1'b0; block_hart = 2'd0; wake_valid = 1'b0; wake_hart = 2'd0;
        redirect_valid = 1'b0; redirect_hart = 2'd0; redirect_pc = 32'd0;

        tick();
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_hart",  32'(issue_hart),  32'd0);
        chk("rst_pc",    issue_pc,         32'd0);
        chk("rst_idle",  32'(idle),        32'd0);
        chk("rst_ready", 32'(hart_ready),  32'hF);
        $display("edge %0d: reset ready=%0h", edge_no, hart_ready);
        reset = 1'b0;

        // Plain round robin, two laps.
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_issue("rr", 2'(i % 4), (i < 4) ? 32'd0 : 32'd4);
        end

        tick(); expect_issue("pre0", 2'd0, 32'd8);
        tick(); expect_issue("pre1", 2'd1, 32'd8);

        // Block hart 1 while it sits in ID, wake it five cycles later.
        block_req = 1'b1; block_hart = 2'd1;
        tick(); expect_issue("blk", 2'd2, 32'd8);
        chk("blk_ready", 32'(hart_ready), 32'hD);
        seq_h[0] = 2'd3; seq_p[0] = 32'd8;
        seq_h[1] = 2'd0; seq_p[1] = 32'd12;
        seq_h[2] = 2'd2; seq_p[2] = 32'd12;
        seq_h[3] = 2'd3; seq_p[3] = 32'd12;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_issue("skip", seq_h[i], seq_p[i]);
        end
        wake_valid = 1'b1; wake_hart = 2'd1;
        tick(); expect_issue("wake", 2'd0, 32'd16);
        chk("wake_ready", 32'(hart_ready), 32'hF);
        tick(); expect_issue("resume", 2'd1, 32'd12);

        // Redirect hart 2 on the very cycle it is granted.
        redirect_valid = 1'b1; redirect_hart = 2'd2; redirect_pc = 32'h100;
        tick(); expect_issue("redir", 2'd2, 32'd16);
        seq_h[0] = 2'd3; seq_p[0] = 32'd16;
        seq_h[1] = 2'd0; seq_p[1] = 32'd20;
        seq_h[2] = 2'd1; seq_p[2] = 32'd16;
        seq_h[3] = 2'd2; seq_p[3] = 32'h100;
        seq_h[4] = 2'd3; seq_p[4] = 32'd20;
        seq_h[5] = 2'd0; seq_p[5] = 32'd24;
        seq_h[6] = 2'd1; seq_p[6] = 32'd20;
        seq_h[7] = 2'd2; seq_p[7] = 32'h104;
        for (int i = 0; i < 8; i++) begin
            tick(); expect_issue("postredir", seq_h[i], seq_p[i]);
        end

        // Three stalled cycles; a block applied during the stall lands in hart_ready at once.
        stall = 1'b1; block_req = 1'b1; block_hart = 2'd3;
        tick(); expect_issue("stall0", 2'd2, 32'h104);
        chk("stall_ready", 32'(hart_ready), 32'h7);
        tick(); expect_issue("stall1", 2'd2, 32'h104);
        tick(); expect_issue("stall2", 2'd2, 32'h104);
        stall = 1'b0;
        tick(); expect_issue("unstall0", 2'd0, 32'd28);
        tick(); expect_issue("unstall1", 2'd1, 32'd24);
        tick(); expect_issue("unstall2", 2'd2, 32'h108);
        tick(); expect_issue("unstall3", 2'd0, 32'd32);

        // No enabled harts, then every hart in WAIT.
        hart_enable = 4'h0;
        tick(); expect_idle("noen", 2'd0, 32'd32);
        for (int i = 0; i < 3; i++) begin
            block_req = 1'b1; block_hart = 2'(i);
            tick(); expect_idle("blkall", 2'd0, 32'd32);
        end
        chk("allwait_ready", 32'(hart_ready), 32'h0);
        hart_enable = 4'hF;
        tick(); expect_idle("allwait", 2'd0, 32'd32);
        wake_valid = 1'b1; wake_hart = 2'd3;
        tick(); expect_idle("wake3_lat", 2'd0, 32'd32);
        chk("wake3_ready", 32'(hart_ready), 32'h8);
        tick(); expect_issue("wake3", 2'd3, 32'd24);

        // Block and wake of hart 0 together: block wins.
        block_req = 1'b1; block_hart = 2'd0; wake_valid = 1'b1; wake_hart = 2'd0;
        tick(); expect_issue("bw_same", 2'd3, 32'd28);
        chk("bw_same_ready", 32'(hart_ready), 32'h8);
        // Block of hart 3 and wake of hart 1 together: both take effect.
        block_req = 1'b1; block_hart = 2'd3; wake_valid = 1'b1; wake_hart = 2'd1;
        tick(); expect_idle("bw_diff", 2'd3, 32'd28);
        chk("bw_diff_ready", 32'(hart_ready), 32'h2);
        tick(); expect_issue("bw_diff_issue", 2'd1, 32'd28);

        // Reset wins over stall and a simultaneous wake, and clears every WAIT.
        reset = 1'b1; stall = 1'b1; wake_valid = 1'b1; wake_hart = 2'd2;
        tick();
        chk("rst2_ready", 32'(hart_ready),  32'hF);
        chk("rst2_valid", 32'(issue_valid), 32'd0);
        chk("rst2_hart",  32'(issue_hart),  32'd0);
        chk("rst2_pc",    issue_pc,         32'd0);
        chk("rst2_idle",  32'(idle),        32'd0);
        $display("edge %0d: reset during WAIT ready=%0h", edge_no, hart_ready);
        reset = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_issue("boot", 2'(i), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hart_scheduler.md
HART_SCHEDULER -- requirements
Module: hart_scheduler

Interface
REQ-001 Parameter: BOOT_PC, 32'h0000_0000, reset PC loaded into every hart.
REQ-002 Parameter: PC_STEP, 4, PC increment per issued instruction.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hart_enable  in  4  bit h=1 allows hart h to be scheduled.
REQ-006 stall  in  1  pipeline stall; freezes the issue registers and the round-robin pointer.
REQ-007 block_req  in  1  instruction in ID is a branch/jump/load/store; block its hart.
REQ-008 block_hart  in  2  hart ID for block_req.
REQ-009 wake_valid  in  1  outstanding op of a hart resolved.
REQ-010 wake_hart  in  2  hart ID for wake_valid.
REQ-011 redirect_valid  in  1  load a new PC into one hart.
REQ-012 redirect_hart  in  2  hart ID for redirect.
REQ-013 redirect_pc  in  32  new PC value.
REQ-014 issue_valid  out  1  registered; issue_pc/issue_hart valid this cycle.
REQ-015 issue_hart  out  2  registered hart ID for fetch (feeds mhartID down the pipe).
REQ-016 issue_pc  out  32  registered fetch PC.
REQ-017 hart_ready  out  4  bit h=1 when hart h is in RUN state.
REQ-018 idle  out  1  registered; 1 when the last unstalled cycle found no eligible hart.

Function
REQ-019 Hold per hart a 32-bit PC register and a 1-bit state: RUN or WAIT.
REQ-020 Eligible(h) = hart_enable[h] & state(h)==RUN & !(block_req & block_hart==h).
REQ-021 Arbitration is round-robin: search order last+1, last+2, last+3, last (mod 4), where last is the 2-bit pointer; the first eligible hart wins.
REQ-022 On an edge with !stall and a winner g: issue_valid<=1, issue_hart<=g, issue_pc<=PC(g), last<=g, PC(g)<=PC(g)+PC_STEP (modulo 2^32), idle<=0.
REQ-023 On an edge with !stall and no eligible hart: issue_valid<=0, idle<=1; issue_hart, issue_pc, last and all PCs hold.
REQ-024 On an edge with stall=1: issue_valid, issue_hart, issue_pc, idle, last and PC increments hold.
REQ-025 block_req sets state(block_hart)<=WAIT on the edge, regardless of stall.
REQ-026 wake_valid sets state(wake_hart)<=RUN on the edge, regardless of stall.
REQ-027 block_req and wake_valid on the same hart in the same cycle: block wins (WAIT).
REQ-028 block_req and wake_valid on different harts in the same cycle: both apply.
REQ-029 redirect_valid sets PC(redirect_hart)<=redirect_pc on the edge, regardless of stall or state.
REQ-030 Redirect and issue on the same hart in the same cycle: issue_pc takes the old PC; PC(h)<=redirect_pc (redirect overrides the increment).
REQ-031 Redirect does not change hart state; software wakes a hart with wake_valid.
REQ-032 wake_valid on a hart already in RUN and block_req on a hart already in WAIT are no-ops.
REQ-033 hart_enable deasserted mid-run: the hart is excluded from arbitration; its PC and state are retained.
REQ-034 Latency: a hart woken on edge N is eligible for the grant on edge N+1 and appears on issue_* after edge N+1.

Reset
REQ-035 On a clk edge with reset=1: all PCs<=BOOT_PC, all states<=RUN, last<=2'd3, issue_valid<=0, issue_hart<=0, issue_pc<=BOOT_PC, idle<=0.
REQ-036 reset has priority over stall, block, wake and redirect; it also aborts any pending WAIT.

Verification
REQ-037 Reset, hart_enable=4'hF, no other inputs, 8 cycles -> issue_hart sequence 0,1,2,3,0,1,2,3; issue_pc 0,0,0,0,4,4,4,4.
REQ-038 Block hart 1 while hart 1 is in ID, then wake it 5 cycles later -> hart 1 is skipped (sequence 2,3,0,2,...) until the cycle after wake; hart 1 then resumes at its un-incremented PC.
REQ-039 Redirect hart 2 to 32'h100 in the same cycle it is granted -> that issue shows the old PC; the next hart-2 issue shows 32'h100, then 32'h104.
REQ-040 stall=1 for 3 cycles -> issue_* and idle are frozen; a block/wake applied during the stall is reflected in hart_ready immediately and in arbitration after the stall releases.
REQ-041 All harts blocked, or hart_enable=0 -> issue_valid=0, idle=1; a single wake of hart 3 -> next issue_hart=3, idle=0.
REQ-042 Block and wake on hart 0 in the same cycle -> hart_ready[0]=0; reset asserted while harts are in WAIT -> hart_ready=4'hF and all PCs=BOOT_PC after the edge.
